// File: rtl/spike_encoder_if.sv
// Handshake and axon bundle for the rate-coding spike encoder.
// master is the encoder (transmit end of the axons); slave is the producer/consumer side.
interface spike_encoder_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned VAL_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N_CH*VAL_W-1:0]   in_data;
    logic                    abort;
    logic [N_CH-1:0]         axon;
    logic                    step;
    logic                    busy;
    logic                    done;

    modport master (
        input  in_valid, in_data, abort,
        output in_ready, axon, step, busy, done
    );

    modport slave (
        output in_valid, in_data, abort,
        input  in_ready, axon, step, busy, done
    );
endinterface

// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: one intensity vector in, WINDOW timesteps of accumulator-carry spikes out.
// Define SPIKE_ENC_ROUND_EN to seed the accumulators at half scale (round-to-nearest spike counts).
module spike_encoder #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned VAL_W  = 8,
    parameter int unsigned WINDOW = 100
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    spike_encoder_if.master bus
);

    localparam int unsigned CntW = $clog2(WINDOW + 1);

`ifdef SPIKE_ENC_ROUND_EN
    localparam logic [VAL_W-1:0] Seed = {1'b1, {(VAL_W-1){1'b0}}};
`else
    localparam logic [VAL_W-1:0] Seed = '0;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [VAL_W-1:0]    val_q [N_CH];
    logic [VAL_W-1:0]    val_d [N_CH];
    logic [VAL_W-1:0]    acc_q [N_CH];
    logic [VAL_W-1:0]    acc_d [N_CH];
    logic [VAL_W:0]      sum   [N_CH];
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [N_CH-1:0]     axon_q, axon_d;
    logic                step_q, step_d;
    logic                done_q, done_d;
    logic                last_step;

    assign last_step = (cnt_q == CntW'(WINDOW - 1));

    // Carry out of each accumulator is the spike; it is never saturated.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            sum[c] = {1'b0, acc_q[c]} + {1'b0, val_q[c]};
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        axon_d  = '0;
        step_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    for (int c = 0; c < N_CH; c++) begin
                        val_d[c] = bus.in_data[c*VAL_W +: VAL_W];
                        acc_d[c] = Seed;
                    end
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    for (int c = 0; c < N_CH; c++) begin
                        acc_d[c]  = sum[c][VAL_W-1:0];
                        axon_d[c] = sum[c][VAL_W];
                    end
                    step_d = 1'b1;
                    cnt_d  = cnt_q + CntW'(1);
                    if (last_step) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // First edge in DONE raises done; the following edge drops it and releases.
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            axon_q  <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                val_q[c] <= '0;
                acc_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            axon_q  <= axon_d;
            step_q  <= step_d;
            done_q  <= done_d;
            for (int c = 0; c < N_CH; c++) begin
                val_q[c] <= val_d[c];
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign bus.in_ready = (state_q == StIdle);
    assign bus.busy     = (state_q != StIdle);
    assign bus.axon     = axon_q;
    assign bus.step     = step_q;
    assign bus.done     = done_q;

endmodule
